// File: rtl/iq_write.sv
// Transmit-side IQ packer: pops quantized I/Q pairs, dequantizes with half-up rounding, packs {Q,I} into one word.
// Optional clamping instead of wrap-around is enabled by defining IQ_WRITE_SAT_EN.
module iq_write #(
  parameter int DATA_WIDTH     = 32,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int QUANTIZE_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [DATA_WIDTH-1:0] q_data_in,
  output logic                  in_rd_en,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  busy,
  output logic [31:0]           word_count,
  output logic                  sat_event
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam logic signed [DATA_WIDTH:0] ROUND_C =
    {{DATA_WIDTH{1'b0}}, 1'b1} << (QUANTIZE_WIDTH - 1);
`ifdef IQ_WRITE_SAT_EN
  localparam logic signed [DATA_WIDTH:0] SAT_MAX_C =
    {{(DATA_WIDTH - SAMPLE_WIDTH + 2){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SAT_MIN_C =
    {{(DATA_WIDTH - SAMPLE_WIDTH + 2){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};
`endif

  // Returns {clamped_flag, sample}; the extra bit keeps the rounding add from overflowing.
  function automatic logic [SAMPLE_WIDTH:0] dequant(input logic [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH:0] ext_v;
    logic signed [DATA_WIDTH:0] shf_v;
    ext_v = signed'({x[DATA_WIDTH-1], x});
    shf_v = (ext_v + ROUND_C) >>> QUANTIZE_WIDTH;
`ifdef IQ_WRITE_SAT_EN
    if (shf_v > SAT_MAX_C) begin
      return {1'b1, SAT_MAX_C[SAMPLE_WIDTH-1:0]};
    end else if (shf_v < SAT_MIN_C) begin
      return {1'b1, SAT_MIN_C[SAMPLE_WIDTH-1:0]};
    end else begin
      return {1'b0, shf_v[SAMPLE_WIDTH-1:0]};
    end
`else
    return {1'b0, shf_v[SAMPLE_WIDTH-1:0]};
`endif
  endfunction

  state_t                  state_r, state_nx_s;
  logic [DATA_WIDTH-1:0]   i_cap_r, q_cap_r;
  logic [DATA_WIDTH-1:0]   fifo_din_r;
  logic [31:0]             word_count_r;
  logic                    busy_r, sat_event_r;
  logic                    in_rd_en_s, fifo_wr_en_s;
  logic [SAMPLE_WIDTH:0]   i_res_s, q_res_s;

  // Next-state and pop/write strobes; the pop is masked while reset is held.
  always_comb begin
    state_nx_s   = state_r;
    in_rd_en_s   = 1'b0;
    fifo_wr_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_rd_en_s = in_valid & reset;
        if (in_valid) begin
          state_nx_s = CONVERT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONVERT: begin
        state_nx_s = WRITE;
      end
      WRITE: begin
        if (!fifo_full) begin
          fifo_wr_en_s = 1'b1;
          if (in_valid) begin
            in_rd_en_s = reset;
            state_nx_s = CONVERT;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = WRITE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Dequantize the captured pair.
  always_comb begin
    i_res_s = dequant(i_cap_r);
    q_res_s = dequant(q_cap_r);
  end

  // State, capture, packing and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      i_cap_r      <= {DATA_WIDTH{1'b0}};
      q_cap_r      <= {DATA_WIDTH{1'b0}};
      fifo_din_r   <= {DATA_WIDTH{1'b0}};
      word_count_r <= 32'd0;
      busy_r       <= 1'b0;
      sat_event_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      if (in_rd_en_s) begin
        i_cap_r <= i_data_in;
        q_cap_r <= q_data_in;
      end
      if (state_r == CONVERT) begin
        fifo_din_r  <= {q_res_s[SAMPLE_WIDTH-1:0], i_res_s[SAMPLE_WIDTH-1:0]};
        sat_event_r <= i_res_s[SAMPLE_WIDTH] | q_res_s[SAMPLE_WIDTH];
      end else begin
        sat_event_r <= 1'b0;
      end
      if (fifo_wr_en_s) begin
        word_count_r <= word_count_r + 32'd1;
      end
    end
  end

  assign in_rd_en   = in_rd_en_s;
  assign fifo_wr_en = fifo_wr_en_s;
  assign fifo_din   = fifo_din_r;
  assign busy       = busy_r;
  assign word_count = word_count_r;
  assign sat_event  = sat_event_r;

endmodule

// File: tb/tb_iq_write.sv
// Self-checking bench for iq_write: table-driven single transactions plus backpressure, streaming and reset sequences.
module tb_iq_write;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] i_data_in, q_data_in;
  logic        in_rd_en, fifo_full, fifo_wr_en, busy, sat_event;
  logic [31:0] fifo_din, word_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_wc = 32'd0;

  iq_write dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .i_data_in(i_data_in), .q_data_in(q_data_in), .in_rd_en(in_rd_en),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .busy(busy), .word_count(word_count), .sat_event(sat_event)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
    logic [31:0] din_wrap;
    logic [31:0] din_sat;
    logic        sat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One isolated transaction with the fifo ready.
  task automatic run_one(input vec_t v);
    logic [31:0] exp_din;
    logic        exp_sat;
`ifdef IQ_WRITE_SAT_EN
    exp_din = v.din_sat;
    exp_sat = v.sat;
`else
    exp_din = v.din_wrap;
    exp_sat = 1'b0;
`endif
    @(negedge clock);
    in_valid = 1'b1; i_data_in = v.i; q_data_in = v.q; fifo_full = 1'b0;
    #1 chk("rd_en_idle", {31'd0, in_rd_en}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk("busy_convert", {31'd0, busy}, 32'd1);
    chk("wr_en_convert", {31'd0, fifo_wr_en}, 32'd0);
    @(negedge clock);
    chk("wr_en_write", {31'd0, fifo_wr_en}, 32'd1);
    chk("din", fifo_din, exp_din);
    chk("sat_event", {31'd0, sat_event}, {31'd0, exp_sat});
    exp_wc++;
    @(negedge clock);
    chk("sat_event_clear", {31'd0, sat_event}, 32'd0);
    chk("word_count", word_count, exp_wc);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs [9];
  logic [31:0] held_din;
  logic [15:0] k16;

  initial begin
    vecs[0] = '{32'h0000_0400, 32'hFFFF_FC00, 32'hFFFF_0001, 32'hFFFF_0001, 1'b0};
    vecs[1] = '{32'h0000_0200, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[2] = '{32'h0000_01FF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FE00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FDFF, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
    vecs[5] = '{32'h0200_0000, 32'h0000_0000, 32'h0000_8000, 32'h0000_7FFF, 1'b1};
    vecs[6] = '{32'hFDFF_FC00, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_8000, 1'b1};
    vecs[7] = '{32'hFFFF_F000, 32'h00AB_CD00, 32'h2AF3_FFFC, 32'h2AF3_FFFC, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};

    // Reset with in_valid high: everything must stay quiet.
    reset = 1'b0; in_valid = 1'b1; fifo_full = 1'b0;
    i_data_in = 32'h0000_0400; q_data_in = 32'h0000_0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sat", {31'd0, sat_event}, 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    chk("rst_wc", word_count, 32'd0);
    reset = 1'b1;
    #1 chk("rd_en_after_rst", {31'd0, in_rd_en}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk("first_edge_capture", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("first_din", fifo_din, 32'h0000_0001);
    chk("first_wr_en", {31'd0, fifo_wr_en}, 32'd1);
    exp_wc++;
    @(negedge clock);

    foreach (vecs[n]) run_one(vecs[n]);

    // Backpressure: five stalled cycles in WRITE, in_valid high but no pop.
    @(negedge clock);
    in_valid = 1'b1; i_data_in = 32'h0000_0C00; q_data_in = 32'h0000_1400; fifo_full = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    held_din = fifo_din;
    chk("bp_din", held_din, 32'h0005_0003);
    in_valid = 1'b1; i_data_in = 32'h0000_7C00;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("bp_rd_en", {31'd0, in_rd_en}, 32'd0);
      chk("bp_din_stable", fifo_din, 32'h0005_0003);
      chk("bp_wc", word_count, exp_wc);
      @(negedge clock);
    end
    in_valid = 1'b0; fifo_full = 1'b0;
    #1 chk("bp_release_wr", {31'd0, fifo_wr_en}, 32'd1);
    exp_wc++;
    @(negedge clock);
    chk("bp_wc_after", word_count, exp_wc);
    chk("bp_no_dup", {31'd0, fifo_wr_en}, 32'd0);

    // Streaming: 8 pairs back to back, one write every 2 cycles.
    @(negedge clock);
    in_valid = 1'b1; i_data_in = 32'd0; q_data_in = 32'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("st_conv_wr", {31'd0, fifo_wr_en}, 32'd0);
      if (k == 7) begin
        in_valid = 1'b0;
      end else begin
        i_data_in = 32'(k + 1) << 10;
        q_data_in = (32'd0 - 32'(k + 1)) << 10;
      end
      @(negedge clock);
      k16 = 16'(k);
      chk("st_wr_en", {31'd0, fifo_wr_en}, 32'd1);
      chk("st_din", fifo_din, {16'd0 - k16, k16});
      chk("st_rd_en", {31'd0, in_rd_en}, {31'd0, (k != 7)});
      exp_wc++;
    end
    @(negedge clock);
    chk("st_wc", word_count, exp_wc);
    chk("st_idle", {31'd0, busy}, 32'd0);

    // Reset during CONVERT discards the pair and clears the count.
    in_valid = 1'b1; i_data_in = 32'h0000_0800;
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_din", fifo_din, 32'd0);
    chk("midrst_wc", word_count, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("midrst_no_wr", {31'd0, fifo_wr_en}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iq_write.md
Name: iq_write

Overview:
- Transmit-side IQ packer, the inverse of the receiver's IQ parse stage.
- Pops quantized fixed-point I/Q sample pairs (QUANTIZE_WIDTH fractional bits) from an upstream show-ahead source.
- Dequantizes each sample to SAMPLE_WIDTH two's-complement with rounding.
- Packs each pair into one DATA_WIDTH word and writes it into a downstream fifo whose format matches what the radio front end consumes. Used by testbench stimulus generators and loopback paths.

Parameters:
- DATA_WIDTH, 32, width of i_data_in, q_data_in and fifo_din; must equal 2*SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16, width of each packed sample.
- QUANTIZE_WIDTH, 10, fractional bits removed by dequantization; must be ≥ 1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid I/Q pair (show-ahead).
- i_data_in  in  DATA_WIDTH  quantized I, signed.
- q_data_in  in  DATA_WIDTH  quantized Q, signed.
- in_rd_en  out  1  pop strobe; the pair is captured on the same edge.
- fifo_full  in  1  downstream fifo full.
- fifo_wr_en  out  1  write strobe.
- fifo_din  out  DATA_WIDTH  packed word.
- busy  out  1  high in any state other than IDLE.
- word_count  out  32  number of words written since reset.
- sat_event  out  1  one-cycle pulse when a sample is clamped.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; in_rd_en, fifo_wr_en, busy, sat_event=0; fifo_din=0; word_count=0; internal registers cleared. Reset mid-operation discards any captured or converted pair; nothing partial is written.
- in_rd_en and fifo_wr_en are combinational from state and inputs; all data paths are registered.
- IDLE: in_rd_en = in_valid. If in_valid, capture i/q on the edge and go to CONVERT.
- CONVERT (1 cycle): per sample, s = (x + 2^(QUANTIZE_WIDTH-1)) >>> QUANTIZE_WIDTH.
  - Compute in DATA_WIDTH+1 bits so the rounding add cannot overflow; rounding is half-up.
  - Result is taken as the low SAMPLE_WIDTH bits (wrap); see Optional Feature.
  - Register fifo_din = {Q_s, I_s}: I in bits [SAMPLE_WIDTH-1:0], Q in the upper half. Byte order is little-endian (byte0 = I lo).
  - Go to WRITE.
- WRITE: fifo_wr_en = ~fifo_full.
  - If fifo_full: hold state. fifo_din is stable and in_rd_en=0.
  - If not full: write occurs and word_count increments (wraps at 2^32).
    - If in_valid is also high, assert in_rd_en in the same cycle, capture the next pair, go to CONVERT (back-to-back).
    - Otherwise go to IDLE.
- Throughput: 1 word per 2 cycles sustained.
- Latency: 2 cycles from the capture edge to the fifo_wr_en cycle, when not full.
- fifo_full asserting mid-WRITE only stalls; no data loss, no duplicate write.
- in_valid dropping while in WRITE is legal; no pop occurs.
- fifo_wr_en never asserts while fifo_full=1. in_rd_en never asserts while in_valid=0.

Optional Feature:
- Macro: IQ_WRITE_SAT_EN.
- Defined: the rounded, shifted value is clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]. sat_event pulses for exactly one cycle (the CONVERT-to-WRITE edge output) if either I or Q clamped.
- Undefined: low bits are kept (wrap) and sat_event is tied 0.

Test Plan:
- Reset, idle: reset low with in_valid=1 -> all outputs 0. After release, first capture happens on the first rising edge.
- Basic pack: I=0x00000400, Q=0xFFFFFC00, fifo_full=0 -> exactly one fifo_wr_en with fifo_din=0xFFFF0001, 2 cycles after capture; word_count=1.
- Rounding: I=0x00000200 -> I field 0x0001. I=0x000001FF -> 0x0000. I=0xFFFFFE00 -> 0x0000. I=0xFFFFFDFF -> 0xFFFF.
- Backpressure: hold fifo_full=1 for 5 cycles in WRITE -> no write, fifo_din stable, in_rd_en=0. Release -> single write and word_count increments by 1.
- Streaming: in_valid held high for 8 pairs with fifo_full=0 -> 8 writes, one every 2 cycles, in order; word_count=8.
- Overflow: I=0x02000000 -> I field 0x8000 and sat_event=0 without macro. With IQ_WRITE_SAT_EN -> 0x7FFF and one sat_event pulse. I=0xFDFFFC00 with macro -> 0x8000 and sat_event pulse.
